// File: rtl/call_frame_ctrl_pkg.sv
// Shared types for the call/return frame controller: stack geometry defaults,
// FSM state encoding, trap codes and the saved frame-record layout.
package call_frame_ctrl_pkg;

  localparam int ST_LOG2_DEPTH_DEF = 8;
  localparam int ST_WIDTH_DEF      = 32;
  localparam int PC_WIDTH_DEF      = 16;
  localparam int FR_LOG2_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TC_NONE      = 2'd0,
    TC_OVERFLOW  = 2'd1,
    TC_UNDERFLOW = 2'd2,
    TC_PROTOCOL  = 2'd3
  } trap_code_t;

  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0]    ret_pc;
    logic [ST_LOG2_DEPTH_DEF:0] base;
  } frame_rec_t;

endpackage

// File: rtl/call_frame_ctrl_frame_lifo.sv
// Push/pop register stack of saved frame records; the top entry is held in a
// register so it is available without a read cycle when a return is accepted.
module frame_lifo #(
  parameter int DW     = 25,
  parameter int LOG2_N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   top,
  output logic [LOG2_N:0] count,
  output logic            full,
  output logic            empty
);

  localparam int N = 1 << LOG2_N;

  logic [DW-1:0]     mem [N];
  logic [LOG2_N-1:0] wr_idx;
  logic [LOG2_N-1:0] below_idx;

  assign full      = (count == (LOG2_N+1)'(N));
  assign empty     = (count == '0);
  assign wr_idx    = count[LOG2_N-1:0];
  assign below_idx = count[LOG2_N-1:0] - LOG2_N'(2);

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

  // Popping reloads the shadow top from the entry underneath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      top   <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
      top   <= din;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
      top   <= (count == (LOG2_N+1)'(1)) ? '0 : mem[below_idx];
    end
  end

endmodule

// File: rtl/call_frame_ctrl.sv
// Call/return frame controller: saves caller frames, drives the operand stack's
// call/return ports, and zero-fills callee locals one word per cycle.
module call_frame_ctrl
  import call_frame_ctrl_pkg::*;
#(
  parameter int ST_LOG2_DEPTH = ST_LOG2_DEPTH_DEF,
  parameter int ST_WIDTH      = ST_WIDTH_DEF,
  parameter int PC_WIDTH      = PC_WIDTH_DEF,
  parameter int FR_LOG2_DEPTH = FR_LOG2_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     call_req,
  input  logic [PC_WIDTH-1:0]      call_ret_pc,
  input  logic [7:0]               call_param_num,
  input  logic [7:0]               call_local_num,
  output logic                     call_ack,
  input  logic                     ret_req,
  output logic                     ret_ack,
  output logic                     ret_pc_valid,
  output logic [PC_WIDTH-1:0]      ret_pc,
  input  logic [ST_LOG2_DEPTH:0]   top_pointer,
  output logic                     os_call,
  output logic [7:0]               os_alloc_size,
  output logic                     os_return,
  output logic [ST_LOG2_DEPTH-1:0] os_func_tag,
  output logic                     zf_local_set,
  output logic [ST_LOG2_DEPTH:0]   zf_l_addr,
  output logic [ST_WIDTH-1:0]      zf_data,
  output logic [ST_LOG2_DEPTH:0]   frame_base,
  output logic                     busy,
  output logic [FR_LOG2_DEPTH:0]   frame_depth,
  output logic                     trap,
  output logic [1:0]               trap_code
);

  localparam int SP = ST_LOG2_DEPTH + 1;
  localparam logic [SP-1:0] ST_CAP = {1'b1, {ST_LOG2_DEPTH{1'b0}}};

  state_t     state, state_nxt;
  trap_code_t code_q, fault_code;
  logic       call_ok, ret_ok, fault;

  logic [SP-1:0] fill_ptr;
  logic [7:0]    fill_cnt;
  logic [SP-1:0] par_ext, loc_ext;

  frame_rec_t push_rec, top_rec;
  logic       lifo_full, lifo_empty;

  assign par_ext = {{(SP-8){1'b0}}, call_param_num};
  assign loc_ext = {{(SP-8){1'b0}}, call_local_num};

  assign push_rec.ret_pc = call_ret_pc;
  assign push_rec.base   = frame_base;

  frame_lifo #(
    .DW     ($bits(frame_rec_t)),
    .LOG2_N (FR_LOG2_DEPTH)
  ) u_frame_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (call_ok),
    .pop   (ret_ok),
    .din   (push_rec),
    .top   (top_rec),
    .count (frame_depth),
    .full  (lifo_full),
    .empty (lifo_empty)
  );

  // Request decode; overflow takes precedence over underflow on a call.
  always_comb begin
    call_ok    = 1'b0;
    ret_ok     = 1'b0;
    fault      = 1'b0;
    fault_code = TC_NONE;
    if (state == ST_IDLE) begin
      if (call_req && ret_req) begin
        fault      = 1'b1;
        fault_code = TC_PROTOCOL;
      end else if (call_req) begin
        if (lifo_full || (top_pointer + loc_ext > ST_CAP)) begin
          fault      = 1'b1;
          fault_code = TC_OVERFLOW;
        end else if (par_ext > top_pointer) begin
          fault      = 1'b1;
          fault_code = TC_UNDERFLOW;
        end else begin
          call_ok = 1'b1;
        end
      end else if (ret_req) begin
        if (lifo_empty) begin
          fault      = 1'b1;
          fault_code = TC_UNDERFLOW;
        end else begin
          ret_ok = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fault)                                 state_nxt = ST_TRAP;
        else if (call_ok && call_local_num != 8'd0) state_nxt = ST_FILL;
      end
      ST_FILL: if (fill_cnt == 8'd1) state_nxt = ST_IDLE;
      ST_TRAP: state_nxt = ST_TRAP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    call_ack      = call_ok;
    os_call       = call_ok;
    os_alloc_size = call_ok ? call_local_num : 8'd0;
    ret_ack       = ret_ok;
    os_return     = ret_ok;
    os_func_tag   = ret_ok ? frame_base[ST_LOG2_DEPTH-1:0] : '0;
    busy          = (state == ST_FILL);
    zf_local_set  = (state == ST_FILL);
    zf_l_addr     = (state == ST_FILL) ? fill_ptr : '0;
    zf_data       = '0;
    trap          = (state == ST_TRAP);
    trap_code     = code_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_base   <= '0;
      fill_ptr     <= '0;
      fill_cnt     <= '0;
      ret_pc       <= '0;
      ret_pc_valid <= 1'b0;
      code_q       <= TC_NONE;
    end else begin
      ret_pc_valid <= ret_ok;
      if (fault) code_q <= fault_code;
      if (call_ok) begin
        frame_base <= top_pointer - par_ext;
        fill_ptr   <= top_pointer;
        fill_cnt   <= call_local_num;
      end else if (state == ST_FILL) begin
        fill_ptr <= fill_ptr + 1'b1;
        fill_cnt <= fill_cnt - 8'd1;
      end
      if (ret_ok) begin
        frame_base <= top_rec.base;
        ret_pc     <= top_rec.ret_pc;
      end
    end
  end

endmodule

// File: tb/tb_call_frame_ctrl.sv
// Bench for call_frame_ctrl: vector table, hand-written trap/reset sequences,
// and a randomized call/return run against a queue-based frame model.
module tb_call_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        call_req, ret_req;
  logic [15:0] call_ret_pc;
  logic [7:0]  call_param_num, call_local_num;
  logic [8:0]  top_pointer;
  logic        call_ack, ret_ack, ret_pc_valid, os_call, os_return;
  logic [15:0] ret_pc;
  logic [7:0]  os_alloc_size, os_func_tag;
  logic        zf_local_set, busy, trap;
  logic [8:0]  zf_l_addr, frame_base;
  logic [31:0] zf_data;
  logic [4:0]  frame_depth;
  logic [1:0]  trap_code;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  call_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .call_req(call_req), .call_ret_pc(call_ret_pc),
    .call_param_num(call_param_num), .call_local_num(call_local_num),
    .call_ack(call_ack), .ret_req(ret_req), .ret_ack(ret_ack),
    .ret_pc_valid(ret_pc_valid), .ret_pc(ret_pc), .top_pointer(top_pointer),
    .os_call(os_call), .os_alloc_size(os_alloc_size), .os_return(os_return),
    .os_func_tag(os_func_tag), .zf_local_set(zf_local_set),
    .zf_l_addr(zf_l_addr), .zf_data(zf_data), .frame_base(frame_base),
    .busy(busy), .frame_depth(frame_depth), .trap(trap), .trap_code(trap_code)
  );

  typedef struct {
    logic cr, rr;
    int   tp, p, l, pc;
    logic e_cack;
    int   e_alloc;
    logic e_rack;
    int   e_tag;
    logic e_busy;
    int   e_zf;
    logic e_rpv;
    int   e_rpc, e_base, e_depth;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic cr, rr, input int tp, p, l, pc,
                              input logic cack, input int alloc,
                              input logic rack, input int tag,
                              input logic bsy, input int zf,
                              input logic rpv, input int rpc, base, depth);
    vec_t v;
    v.cr = cr; v.rr = rr; v.tp = tp; v.p = p; v.l = l; v.pc = pc;
    v.e_cack = cack; v.e_alloc = alloc; v.e_rack = rack; v.e_tag = tag;
    v.e_busy = bsy; v.e_zf = zf; v.e_rpv = rpv; v.e_rpc = rpc;
    v.e_base = base; v.e_depth = depth;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, rr, input int tp, p, l, pc);
    call_req       = cr;
    ret_req        = rr;
    top_pointer    = 9'(tp);
    call_param_num = 8'(p);
    call_local_num = 8'(l);
    call_ret_pc    = 16'(pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_trap(input string nm, input int code);
    @(negedge clk);
    chk({nm, "_trap"}, 32'(trap), 32'd1);
    chk({nm, "_code"}, 32'(trap_code), 32'(code));
  endtask

  // Reference frame model: a LIFO of {pc, base} plus the current base.
  logic [15:0] m_pc [$];
  int          m_base [$];
  int          cur_base;

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst_call_ack", 32'(call_ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_zf_set", 32'(zf_local_set), 0);
    chk("rst_trap", 32'({trap, trap_code}), 0);
    chk("rst_base", 32'(frame_base), 0);
    chk("rst_depth", 32'(frame_depth), 0);
    chk("rst_rpv", 32'(ret_pc_valid), 0);

    // Call (tp=3,p=2,l=3), a second call held through FILL, then two returns.
    tbl[0]  = mk(0,0,3,0,0,0,      0,0,0,0, 0,0, 0,0,     0,0);
    tbl[1]  = mk(1,0,3,2,3,'h40,   1,3,0,0, 0,0, 0,0,     0,0);
    tbl[2]  = mk(0,0,6,0,0,0,      0,0,0,0, 1,3, 0,0,     1,1);
    tbl[3]  = mk(1,0,6,0,0,'h80,   0,0,0,0, 1,4, 0,0,     1,1);
    tbl[4]  = mk(1,0,6,0,0,'h80,   0,0,0,0, 1,5, 0,0,     1,1);
    tbl[5]  = mk(1,0,6,0,0,'h80,   1,0,0,0, 0,0, 0,0,     1,1);
    tbl[6]  = mk(0,0,6,0,0,0,      0,0,0,0, 0,0, 0,0,     6,2);
    tbl[7]  = mk(0,1,6,0,0,0,      0,0,1,6, 0,0, 0,0,     6,2);
    tbl[8]  = mk(0,0,6,0,0,0,      0,0,0,0, 0,0, 1,'h80,  1,1);
    tbl[9]  = mk(0,1,6,0,0,0,      0,0,1,1, 0,0, 0,'h80,  1,1);
    tbl[10] = mk(0,0,6,0,0,0,      0,0,0,0, 0,0, 1,'h40,  0,0);
    tbl[11] = mk(0,0,6,0,0,0,      0,0,0,0, 0,0, 0,'h40,  0,0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].cr, tbl[i].rr, tbl[i].tp, tbl[i].p, tbl[i].l, tbl[i].pc);
      @(negedge clk);
      chk($sformatf("row%0d_call_ack", i), 32'(call_ack), 32'(tbl[i].e_cack));
      chk($sformatf("row%0d_os_call", i), 32'(os_call), 32'(tbl[i].e_cack));
      chk($sformatf("row%0d_alloc", i), 32'(os_alloc_size), 32'(tbl[i].e_alloc));
      chk($sformatf("row%0d_ret_ack", i), 32'(ret_ack), 32'(tbl[i].e_rack));
      chk($sformatf("row%0d_os_return", i), 32'(os_return), 32'(tbl[i].e_rack));
      if (tbl[i].e_rack) chk($sformatf("row%0d_tag", i), 32'(os_func_tag), 32'(tbl[i].e_tag));
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_zf_set", i), 32'(zf_local_set), 32'(tbl[i].e_busy));
      if (tbl[i].e_busy) chk($sformatf("row%0d_zf_addr", i), 32'(zf_l_addr), 32'(tbl[i].e_zf));
      chk($sformatf("row%0d_zf_data", i), zf_data, 0);
      chk($sformatf("row%0d_rpv", i), 32'(ret_pc_valid), 32'(tbl[i].e_rpv));
      if (tbl[i].e_rpc != 0) chk($sformatf("row%0d_ret_pc", i), 32'(ret_pc), 32'(tbl[i].e_rpc));
      chk($sformatf("row%0d_base", i), 32'(frame_base), 32'(tbl[i].e_base));
      chk($sformatf("row%0d_depth", i), 32'(frame_depth), 32'(tbl[i].e_depth));
      chk($sformatf("row%0d_trap", i), 32'(trap), 0);
      tick();
    end

    // 16 nested calls fill the record store; the 17th overflows.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, i, 0, 0, 'h100 + i);
      @(negedge clk);
      chk($sformatf("nest%0d_ack", i), 32'(call_ack), 1);
      tick();
      drive(0, 0, i, 0, 0, 0);
      tick();
    end
    @(negedge clk);
    chk("nest_depth16", 32'(frame_depth), 16);
    tick();
    drive(1, 0, 20, 0, 0, 'h200);
    @(negedge clk);
    chk("ovf17_ack", 32'(call_ack), 0);
    chk("ovf17_os_call", 32'(os_call), 0);
    tick();
    chk_trap("ovf17", 1);
    tick();
    drive(0, 1, 20, 0, 0, 0);
    @(negedge clk);
    chk("trap_ret_ack", 32'(ret_ack), 0);
    chk("trap_os_return", 32'(os_return), 0);
    chk("trap_depth", 32'(frame_depth), 16);
    tick();

    do_reset();
    drive(0, 1, 4, 0, 0, 0);
    @(negedge clk);
    chk("ret_empty_ack", 32'(ret_ack), 0);
    tick();
    chk_trap("ret_empty", 2);

    do_reset();
    drive(1, 1, 4, 0, 0, 'h10);
    @(negedge clk);
    chk("both_call_ack", 32'(call_ack), 0);
    chk("both_ret_ack", 32'(ret_ack), 0);
    tick();
    chk_trap("both", 3);

    do_reset();
    drive(1, 0, 2, 5, 0, 'h10);
    @(negedge clk);
    chk("param_unf_ack", 32'(call_ack), 0);
    tick();
    chk_trap("param_unf", 2);

    // Stack-capacity boundary: exactly full is legal, one beyond traps.
    do_reset();
    drive(1, 0, 250, 0, 6, 'h20);
    @(negedge clk);
    chk("cap256_ack", 32'(call_ack), 1);
    tick();
    drive(0, 0, 256, 0, 0, 0);
    repeat (7) tick();
    drive(1, 0, 251, 0, 6, 'h22);
    @(negedge clk);
    chk("cap257_ack", 32'(call_ack), 0);
    tick();
    chk_trap("cap257", 1);

    // Asynchronous reset in the second FILL cycle.
    do_reset();
    drive(1, 0, 10, 1, 4, 'h30);
    @(negedge clk);
    chk("midfill_ack", 32'(call_ack), 1);
    tick();
    drive(0, 0, 14, 0, 0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midfill_rst_busy", 32'(busy), 0);
    chk("midfill_rst_zf", 32'({zf_local_set, zf_l_addr}), 0);
    chk("midfill_rst_base", 32'(frame_base), 0);
    chk("midfill_rst_depth", 32'(frame_depth), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(1, 0, 5, 0, 0, 'h31);
    @(negedge clk);
    chk("postrst_ack", 32'(call_ack), 1);
    chk("postrst_busy", 32'(busy), 0);
    tick();
    drive(0, 0, 5, 0, 0, 0);
    @(negedge clk);
    chk("postrst_depth", 32'(frame_depth), 1);
    chk("postrst_base", 32'(frame_base), 5);
    tick();

    // Randomized legal call/return traffic against the frame model.
    do_reset();
    m_pc.delete();
    m_base.delete();
    cur_base = 0;
    for (int it = 0; it < 300; it++) begin
      if (m_pc.size() == 0 || (m_pc.size() < 16 && $urandom_range(0, 1) == 1)) begin
        int tp, p, l, pc;
        tp = $urandom_range(0, 256);
        l  = $urandom_range(0, (256 - tp) < 4 ? 256 - tp : 4);
        p  = $urandom_range(0, tp > 255 ? 255 : tp);
        pc = $urandom_range(0, 16'hffff);
        drive(1, 0, tp, p, l, pc);
        @(negedge clk);
        chk("rnd_call_ack", 32'(call_ack), 1);
        chk("rnd_alloc", 32'(os_alloc_size), 32'(l));
        m_pc.push_back(16'(pc));
        m_base.push_back(cur_base);
        cur_base = tp - p;
        tick();
        drive(0, 0, tp + l, 0, 0, 0);
        for (int k = 0; k < l; k++) begin
          @(negedge clk);
          chk("rnd_fill_busy", 32'(busy), 1);
          chk("rnd_fill_addr", 32'(zf_l_addr), 32'(tp + k));
          tick();
        end
        @(negedge clk);
        chk("rnd_call_idle", 32'(busy), 0);
        chk("rnd_call_base", 32'(frame_base), 32'(cur_base));
        chk("rnd_call_depth", 32'(frame_depth), 32'(m_pc.size()));
        tick();
      end else begin
        logic [15:0] exp_pc;
        int          exp_base;
        exp_pc   = m_pc.pop_back();
        exp_base = m_base.pop_back();
        drive(0, 1, $urandom_range(0, 256), 0, 0, 0);
        @(negedge clk);
        chk("rnd_ret_ack", 32'(ret_ack), 1);
        chk("rnd_ret_tag", 32'(os_func_tag), 32'(cur_base % 256));
        cur_base = exp_base;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rnd_ret_rpv", 32'(ret_pc_valid), 1);
        chk("rnd_ret_pc", 32'(ret_pc), 32'(exp_pc));
        chk("rnd_ret_base", 32'(frame_base), 32'(cur_base));
        chk("rnd_ret_depth", 32'(frame_depth), 32'(m_pc.size()));
        tick();
      end
    end
    @(negedge clk);
    chk("rnd_no_trap", 32'(trap), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
